rsp_nibble_deser: RTL
=====================

Name: rsp_nibble_deser

Overview:
- Response-side deserializer between the 4-bit off-chip response pins and the core's 32-bit response interface.
- Collects nibbles least-significant first, assembles them into full words, and buffers completed words in a small FIFO.
- Presents buffered words to the core through a valid/ready handshake.
- Counterpart of the on-chip request serializer: the serializer drives the request pins, this block consumes the response pins.

Parameters:
- DataWidth, 32, width of an assembled response word.
- NibWidth, 4, width of one pin beat. DataWidth must be a multiple of NibWidth. Beats = DataWidth/NibWidth (8 at defaults).
- FifoDepth, 2, number of completed words buffered. Must be at least 1.
- TimeoutCycles, 255, stall limit for a partial word. Used only with the optional feature.

Ports:
- clk  input  1  Clock. All logic is on the rising edge.
- rst  input  1  Reset. Synchronous, active-high.
- nib_i  input  NibWidth  Response nibble from the pins.
- nib_valid_i  input  1  Nibble valid, from the pins.
- nib_ready_o  output  1  Nibble accept. Drives the response-ready pin.
- rsp_data_o  output  DataWidth  Assembled word at the FIFO head.
- rsp_valid_o  output  1  FIFO is not empty.
- rsp_ready_i  input  1  Core accepts the head word.
- busy_o  output  1  A partial word is in progress (beat_cnt != 0).
- err_o  output  1  Timeout abort pulse. Tied to 0 when the optional feature is compiled out.

Behaviour:
- Reset: one clock and a synchronous, active-high reset. On rst=1 at a clock edge:
  - beat_cnt, the partial-word register, FIFO pointers and count, all FIFO storage and the timeout counter clear to 0.
  - Resulting outputs: nib_ready_o=1, rsp_valid_o=0, rsp_data_o=0, busy_o=0, err_o=0.
- Reset mid-word discards the partial word. Reset with a non-empty FIFO discards all buffered words. No output pulse is generated.
- Beat accept: a beat is accepted when nib_valid_i && nib_ready_o.
  - Beat k (k = beat_cnt) writes partial[NibWidth*k +: NibWidth].
  - beat_cnt increments and wraps Beats-1 -> 0.
- Word push: accepting beat Beats-1 pushes {nib_i, partial[lower bits]} into the FIFO in the same edge. The partial register then clears.
- nib_ready_o = !(fifo_full && beat_cnt == Beats-1).
  - Beats 0..Beats-2 are accepted even while the FIFO is full. Only the final beat stalls.
  - nib_ready_o must not depend combinationally on rsp_ready_i or nib_valid_i.
  - If the FIFO is full and a pop happens in the same cycle, the final beat is still refused that cycle and is accepted the next cycle.
- Pop: occurs when rsp_valid_o && rsp_ready_i. rsp_data_o is the registered head entry.
  - Latency: a word is visible on rsp_data_o with rsp_valid_o=1 in the first cycle after its final beat is accepted.
- Simultaneous push and pop with 0 < count < FifoDepth: count is unchanged and the pointers both advance.
- Push with the FIFO empty and rsp_ready_i=1: no pass-through. The word still appears next cycle.
- rsp_data_o holds its last head value when the FIFO is empty. rsp_valid_o=0 qualifies it.
- Pointers wrap modulo FifoDepth. FifoDepth need not be a power of two.
- The FIFO never overflows by construction. A pop on empty is impossible because rsp_valid_o=0.
- Implementation form is free: either a state machine (COLLECT/STALL_LAST) or a counter. Externally the behaviour must equal the equations above.

Optional Feature:
- Macro: RSP_NIBBLE_DESER_TIMEOUT_EN.
- With the macro defined:
  - A timeout counter increments each cycle busy_o=1 and no beat is accepted.
  - The counter clears on any accepted beat and whenever busy_o=0.
  - When the counter reaches TimeoutCycles, at that edge: the partial word is discarded, beat_cnt goes to 0, the counter clears, and err_o=1 for exactly the following cycle.
  - A beat accepted in the cycle the limit would be reached takes priority: no abort, and the counter clears.
  - FIFO contents are unaffected by an abort.
- Without the macro: no counter exists, err_o is constant 0, and partial words wait indefinitely.

Test Plan:
- Single word: after reset, drive nibbles F,E,E,B,D,A,E,D on consecutive cycles with valid=1 and rsp_ready_i=1 -> rsp_valid_o=1 with rsp_data_o=0xDEADBEEF exactly one cycle after the 8th beat, for exactly 1 cycle. busy_o=1 during beats 2..8.
- Backpressure: rsp_ready_i=0, send words 0x11111111, 0x22222222, 0x33333333 -> first two buffered. Third word's beats 0..6 accepted, nib_ready_o=0 at beat 7. Raise rsp_ready_i for 1 cycle -> 0x11111111 popped, nib_ready_o=1 the next cycle, beat 7 accepted. Pop order is 0x22222222 then 0x33333333.
- Bubbles: 0x01234567 sent with nib_valid_i low on random cycles (50%) -> identical word assembled, beat_cnt advances only on accepts.
- Reset mid-word: 3 beats of 0xA, then rst=1 for 1 cycle, then full word 0x89ABCDEF -> output is exactly 0x89ABCDEF with no stale nibbles. No output is produced for the aborted partial word.
- Concurrent push/pop: FIFO count=1, rsp_ready_i=1 held while the final beat of the next word is accepted -> count stays 1, head advances, no word lost or duplicated over 10 words.
- Timeout (macro on, TimeoutCycles=4): 2 beats then nib_valid_i=0 -> err_o=1 for one cycle after 4 idle cycles, busy_o=0. Next full word 0xCAFEF00D is correct. Repeat with a beat arriving on the 4th idle cycle -> no err_o pulse.

Source files
------------

// File: rtl/rsp_nibble_deser.sv
// rtl/rsp_nibble_deser.sv - response pin nibble deserializer with word FIFO and valid/ready output
// Optional stall timeout: define RSP_NIBBLE_DESER_TIMEOUT_EN.
module rsp_nibble_deser #(
  parameter int DataWidth     = 32,
  parameter int NibWidth      = 4,
  parameter int FifoDepth     = 2,
  parameter int TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NibWidth-1:0]  nib_i,
  input  logic                 nib_valid_i,
  output logic                 nib_ready_o,
  output logic [DataWidth-1:0] rsp_data_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int Beats = DataWidth / NibWidth;
  localparam int BeatW = (Beats > 1) ? $clog2(Beats) : 1;
  localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
  localparam int CntW  = $clog2(FifoDepth + 1);
  localparam logic [BeatW-1:0] LastBeat = BeatW'(Beats - 1);
  localparam logic [PtrW-1:0]  LastPtr  = PtrW'(FifoDepth - 1);
  localparam logic [CntW-1:0]  FullCnt  = CntW'(FifoDepth);

  logic [BeatW-1:0]     beat_cnt;
  logic [DataWidth-1:0] partial;
  logic [DataWidth-1:0] partial_nxt;
  logic [DataWidth-1:0] mem [FifoDepth];
  logic [DataWidth-1:0] head;
  logic [PtrW-1:0]      wr_ptr, rd_ptr, wr_ptr_inc, rd_ptr_inc;
  logic [CntW-1:0]      count;
  logic                 fifo_full, last_beat, accept, push, pop, abort;

  assign fifo_full   = (count == FullCnt);
  assign last_beat   = (beat_cnt == LastBeat);
  // Only the word-completing beat needs a free slot; earlier beats land in the partial register.
  assign nib_ready_o = !(fifo_full && last_beat);
  assign accept      = nib_valid_i && nib_ready_o;
  assign push        = accept && last_beat;
  assign rsp_valid_o = (count != '0);
  assign pop         = rsp_valid_o && rsp_ready_i;
  assign busy_o      = (beat_cnt != '0);
  assign rsp_data_o  = head;
  assign wr_ptr_inc  = (wr_ptr == LastPtr) ? '0 : wr_ptr + 1'b1;
  assign rd_ptr_inc  = (rd_ptr == LastPtr) ? '0 : rd_ptr + 1'b1;

  always_comb begin
    partial_nxt = partial;
    for (int b = 0; b < Beats; b++) begin
      if (beat_cnt == BeatW'(b)) partial_nxt[b*NibWidth +: NibWidth] = nib_i;
    end
  end

`ifdef RSP_NIBBLE_DESER_TIMEOUT_EN
  localparam int ToW = $clog2(TimeoutCycles + 1);
  logic [ToW-1:0] to_cnt;
  logic           err_q;

  assign abort = busy_o && !accept && (to_cnt == ToW'(TimeoutCycles - 1));
  assign err_o = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q <= abort;
      if (!busy_o || accept || abort) to_cnt <= '0;
      else                            to_cnt <= to_cnt + 1'b1;
    end
  end
`else
  assign abort = 1'b0;
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      partial  <= '0;
    end else if (abort) begin
      beat_cnt <= '0;
      partial  <= '0;
    end else if (accept) begin
      beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      partial  <= last_beat ? '0 : partial_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FifoDepth; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      head   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= partial_nxt;
        wr_ptr      <= wr_ptr_inc;
      end
      if (pop) rd_ptr <= rd_ptr_inc;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
      // head mirrors the entry at rd_ptr and keeps its value once the FIFO drains
      if (pop) begin
        if (count > CntW'(1)) head <= mem[rd_ptr_inc];
        else if (push)        head <= partial_nxt;
      end else if (push && count == '0) begin
        head <= partial_nxt;
      end
    end
  end

endmodule
